fp_align_shift_seq: RTL and testbench



---
 rtl/fp_align_pkg.sv | 18 +
 rtl/align_step_shr.sv | 31 +++
 rtl/fp_align_shift_seq.sv | 118 +++++++++++
 tb/tb_fp_align_shift_seq.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/fp_align_pkg.sv
// Shared definitions for the FP add/sub mantissa alignment stage.
// Holds the default datapath widths and the sequencer state encoding
// used by fp_align_shift_seq and align_step_shr.
package fp_align_pkg;

    localparam int MAN_W     = 24;            // mantissa incl. hidden bit
    localparam int EXP_W     = 8;             // exponent width
    localparam int GRS_W     = 3;             // guard, round, sticky
    localparam int WORK_W    = MAN_W + GRS_W; // alignment work register
    localparam int MAX_SHIFT = 24;            // largest meaningful shift

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/align_step_shr.sv
// One alignment step: logical right shift of the work register by k bits,
// folding every bit shifted out into bit 0 (sticky) so that sticky is
// never lost across successive steps.
//
// Ports:
//   w_in   work register before the step
//   k      shift amount for this step (0..max step)
//   w_out  shifted work register with sticky folded into bit 0
module align_step_shr #(
    parameter int W_W = 27,
    parameter int K_W = 5
) (
    input  logic [W_W-1:0] w_in,
    input  logic [K_W-1:0] k,
    output logic [W_W-1:0] w_out
);
    import fp_align_pkg::*;

    logic [W_W-1:0] mask;
    logic [W_W-1:0] shifted;
    logic           sticky;

    always_comb begin
        // mask selects the k low bits that fall off the end
        mask    = ~({W_W{1'b1}} << k);
        shifted = w_in >> k;
        sticky  = |(w_in & mask);
        w_out   = {shifted[W_W-1:1], shifted[0] | sticky};
    end

endmodule

// File: rtl/fp_align_shift_seq.sv
// Mantissa alignment stage of the FP add/sub datapath.
// Picks the larger-exponent operand and right-shifts the smaller mantissa
// SHIFT_STEP bits per cycle, producing guard/round/sticky. One operation
// in flight; valid/ready handshake on both sides.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid / in_ready  input handshake (ready only in IDLE)
//   exp1, exp2           operand exponents
//   man1, man2           operand mantissas, hidden bit at MSB
//   shift                |exp1-exp2| from the exponent comparator
//   in1_sub_in2          1 = operand 2 has the larger exponent
//   check_qualon         1 = exponent difference exceeds mantissa width
//   out_valid / out_ready output handshake (valid only in DONE)
//   exp_big, man_big     larger-exponent operand
//   man_al, grs          aligned smaller mantissa and its guard/round/sticky
//   swapped              registered copy of in1_sub_in2
module fp_align_shift_seq #(
    parameter int MAN_W      = 24,
    parameter int EXP_W      = 8,
    parameter int SHIFT_STEP = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [EXP_W-1:0] exp1,
    input  logic [EXP_W-1:0] exp2,
    input  logic [MAN_W-1:0] man1,
    input  logic [MAN_W-1:0] man2,
    input  logic [4:0]       shift,
    input  logic             in1_sub_in2,
    input  logic             check_qualon,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [EXP_W-1:0] exp_big,
    output logic [MAN_W-1:0] man_big,
    output logic [MAN_W-1:0] man_al,
    output logic [2:0]       grs,
    output logic             swapped
);
    import fp_align_pkg::*;

    localparam int         AL_W   = MAN_W + GRS_W;
    localparam logic [4:0] STEP_K = 5'(SHIFT_STEP);

    state_t           state;
    logic [AL_W-1:0]  work;
    logic [AL_W-1:0]  work_next;
    logic [4:0]       rem;
    logic [4:0]       k;
    logic [MAN_W-1:0] man_small;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign man_al    = work[AL_W-1:GRS_W];
    assign grs       = work[GRS_W-1:0];

    // Operand 1 is "big" on ties; downstream sorts out equal exponents.
    assign man_small = in1_sub_in2 ? man1 : man2;

    always_comb begin
        k = (rem > STEP_K) ? STEP_K : rem;
    end

    align_step_shr #(
        .W_W(AL_W),
        .K_W(5)
    ) u_step (
        .w_in (work),
        .k    (k),
        .w_out(work_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            work    <= '0;
            rem     <= '0;
            exp_big <= '0;
            man_big <= '0;
            swapped <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        swapped <= in1_sub_in2;
                        exp_big <= in1_sub_in2 ? exp2 : exp1;
                        man_big <= in1_sub_in2 ? man2 : man1;
                        rem     <= shift;
                        if (check_qualon) begin
                            // Too far apart: the whole small mantissa is sticky.
                            work  <= {{(AL_W-1){1'b0}}, |man_small};
                            state <= DONE;
                        end else begin
                            work  <= {man_small, {GRS_W{1'b0}}};
                            state <= (shift == 5'd0) ? DONE : SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    work <= work_next;
                    rem  <= rem - k;
                    if (rem == k) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_align_shift_seq.sv
// Directed bench for fp_align_shift_seq with hand-computed expectations.
module tb_fp_align_shift_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  exp1, exp2;
    logic [23:0] man1, man2;
    logic [4:0]  shift;
    logic        in1_sub_in2;
    logic        check_qualon;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  exp_big;
    logic [23:0] man_big;
    logic [23:0] man_al;
    logic [2:0]  grs;
    logic        swapped;

    int n_cmp = 0;
    int n_err = 0;

    fp_align_shift_seq dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .exp1        (exp1),
        .exp2        (exp2),
        .man1        (man1),
        .man2        (man2),
        .shift       (shift),
        .in1_sub_in2 (in1_sub_in2),
        .check_qualon(check_qualon),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .exp_big     (exp_big),
        .man_big     (man_big),
        .man_al      (man_al),
        .grs         (grs),
        .swapped     (swapped)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present one operation, wait for out_valid (bounded) and check results.
    // When rel is set the result is then consumed and the return to IDLE checked.
    task automatic run_op(input string tag,
                          input logic [7:0] e1, input logic [7:0] e2,
                          input logic [23:0] m1, input logic [23:0] m2,
                          input logic [4:0] sh, input logic sub, input logic cq,
                          input int lat, input logic swp, input logic [7:0] eb,
                          input logic [23:0] mb, input logic [23:0] ma,
                          input logic [2:0] g, input bit rel);
        int edges;
        @(negedge clk);
        exp1 = e1; exp2 = e2; man1 = m1; man2 = m2;
        shift = sh; in1_sub_in2 = sub; check_qualon = cq;
        in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        edges = 0;
        while (!out_valid && edges < 20) begin
            @(posedge clk); #1;
            edges++;
        end
        chk({tag, ".lat"},     edges,   lat);
        chk({tag, ".swapped"}, swapped, swp);
        chk({tag, ".exp_big"}, exp_big, eb);
        chk({tag, ".man_big"}, man_big, mb);
        chk({tag, ".man_al"},  man_al,  ma);
        chk({tag, ".grs"},     grs,     g);
        if (rel) begin
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
            chk({tag, ".in_ready"},  in_ready,  1'b1);
            chk({tag, ".out_valid"}, out_valid, 1'b0);
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        exp1 = '0; exp2 = '0; man1 = '0; man2 = '0;
        shift = '0; in1_sub_in2 = 1'b0; check_qualon = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.in_ready",  in_ready,  1'b1);
        chk("rst.out_valid", out_valid, 1'b0);
        chk("rst.exp_big",   exp_big,   8'h00);
        chk("rst.man_big",   man_big,   24'h0);
        chk("rst.man_al",    man_al,    24'h0);
        chk("rst.grs",       grs,       3'b000);
        chk("rst.swapped",   swapped,   1'b0);
        @(negedge clk);
        rst = 1'b0;

        run_op("sh5", 8'h85, 8'h80, 24'hC00000, 24'h800001, 5'd5, 1'b0, 1'b0,
               2, 1'b0, 8'h85, 24'hC00000, 24'h040000, 3'b001, 1'b1);
        run_op("sh24", 8'h80, 8'h98, 24'hFFFFFF, 24'h900000, 5'd24, 1'b1, 1'b0,
               6, 1'b1, 8'h98, 24'h900000, 24'h000000, 3'b111, 1'b1);
        run_op("cq1", 8'hA0, 8'h10, 24'h900000, 24'h800000, 5'd31, 1'b0, 1'b1,
               0, 1'b0, 8'hA0, 24'h900000, 24'h000000, 3'b001, 1'b1);
        run_op("cq0", 8'hA0, 8'h10, 24'h900000, 24'h000000, 5'd31, 1'b0, 1'b1,
               0, 1'b0, 8'hA0, 24'h900000, 24'h000000, 3'b000, 1'b1);
        run_op("sh0", 8'h7F, 8'h7F, 24'hA00000, 24'hB00000, 5'd0, 1'b0, 1'b0,
               0, 1'b0, 8'h7F, 24'hA00000, 24'hB00000, 3'b000, 1'b1);
        run_op("sh3", 8'h83, 8'h80, 24'h800000, 24'hFFFFFF, 5'd3, 1'b0, 1'b0,
               1, 1'b0, 8'h83, 24'h800000, 24'h1FFFFF, 3'b111, 1'b1);

        // Backpressure: hold the result while new operands are offered.
        run_op("bp", 8'h85, 8'h80, 24'hC00000, 24'h800001, 5'd5, 1'b0, 1'b0,
               2, 1'b0, 8'h85, 24'hC00000, 24'h040000, 3'b001, 1'b0);
        @(negedge clk);
        exp1 = 8'h11; exp2 = 8'h22; man1 = 24'h123456; man2 = 24'h654321;
        shift = 5'd1; in1_sub_in2 = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp.in_ready",  in_ready,  1'b0);
            chk("bp.out_valid", out_valid, 1'b1);
            chk("bp.exp_big",   exp_big,   8'h85);
            chk("bp.man_al",    man_al,    24'h040000);
            chk("bp.grs",       grs,       3'b001);
            chk("bp.swapped",   swapped,   1'b0);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp.rel_in_ready",  in_ready,  1'b1);
        chk("bp.rel_out_valid", out_valid, 1'b0);

        // Reset in the middle of a 20-bit shift abandons the operation.
        @(negedge clk);
        exp1 = 8'h80; exp2 = 8'h94; man1 = 24'hFFFFFF; man2 = 24'hC00000;
        shift = 5'd20; in1_sub_in2 = 1'b1; check_qualon = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("mid.in_ready", in_ready, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rstmid.out_valid", out_valid, 1'b0);
        chk("rstmid.in_ready",  in_ready,  1'b1);
        chk("rstmid.exp_big",   exp_big,   8'h00);
        chk("rstmid.man_big",   man_big,   24'h0);
        chk("rstmid.man_al",    man_al,    24'h0);
        chk("rstmid.grs",       grs,       3'b000);
        chk("rstmid.swapped",   swapped,   1'b0);
        @(negedge clk);
        rst = 1'b0;
        run_op("post", 8'h94, 8'h80, 24'hC00000, 24'h800000, 5'd20, 1'b0, 1'b0,
               5, 1'b0, 8'h94, 24'hC00000, 24'h000008, 3'b000, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
